// File: rtl/standalone_hps_leds_seq.sv
// Avalon-MM LED sequencer: static, blink, rotate and bounce patterns
// stepped by a programmable prescaler tick, with optional one-shot runs.
module standalone_hps_leds_seq #(
    parameter int PRESCALE_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [3:0]  out_port
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_d;
    logic                  en, en_d;
    logic [1:0]            mode, mode_d;
    logic                  oneshot, oneshot_d;
    logic [7:0]            steps, steps_d;
    logic [PRESCALE_W-1:0] period, period_d;
    logic [PRESCALE_W-1:0] cnt, cnt_d;
    logic [3:0]            pattern, pattern_d;
    logic [3:0]            s, s_d;
    logic [3:0]            blink, blink_d;
    logic [3:0]            s_tick, rot_l, rot_r, out_d;
    logic [7:0]            step_cnt, step_d, step_inc;
    logic                  dir, dir_d, dir_tick;
    logic                  done, done_d, done_set;
    logic                  wr, wr_ctrl, wr_period, wr_pattern, wr_status;
    logic                  tick;
    logic                  unused_wdata;

    assign wr         = chipselect & ~write_n;
    assign wr_ctrl    = wr && (address == 2'd0);
    assign wr_period  = wr && (address == 2'd1);
    assign wr_pattern = wr && (address == 2'd2);
    assign wr_status  = wr && (address == 2'd3);

    assign tick     = (state == RUN) && (cnt >= period);
    assign step_inc = step_cnt + 8'd1;
    assign rot_l    = {s[2:0], s[3]};
    assign rot_r    = {s[0], s[3:1]};

    assign unused_wdata = ^writedata;

    // Blink XORs with the pattern captured at start, so later
    // PATTERN writes cannot disturb a running sequence.
    always_comb begin
        s_tick   = s;
        dir_tick = dir;
        unique case (mode)
            2'd0: s_tick = s;
            2'd1: s_tick = s ^ blink;
            2'd2: s_tick = rot_l;
            2'd3: begin
                s_tick = dir ? rot_r : rot_l;
                if (s_tick[3])
                    dir_tick = 1'b1;
                else if (s_tick[0])
                    dir_tick = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state;
        en_d      = en;
        mode_d    = mode;
        oneshot_d = oneshot;
        steps_d   = steps;
        period_d  = period;
        pattern_d = pattern;
        blink_d   = blink;
        s_d       = s;
        cnt_d     = cnt;
        step_d    = step_cnt;
        dir_d     = dir;
        done_set  = 1'b0;

        if (state == RUN) begin
            if (tick) begin
                cnt_d  = '0;
                s_d    = s_tick;
                dir_d  = dir_tick;
                step_d = step_inc;
                if (oneshot && (step_inc == steps)) begin
                    state_d  = IDLE;
                    en_d     = 1'b0;
                    done_set = 1'b1;
                end
            end else begin
                cnt_d = cnt + PRESCALE_W'(1);
            end
        end

        // A bus write to CTRL overrides whatever the tick decided.
        if (wr_ctrl) begin
            en_d      = writedata[0];
            mode_d    = writedata[2:1];
            oneshot_d = writedata[3];
            steps_d   = writedata[15:8];
            if (writedata[0]) begin
                state_d = RUN;
                s_d     = pattern;
                blink_d = pattern;
                cnt_d   = '0;
                step_d  = 8'd0;
                dir_d   = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end

        if (wr_period)
            period_d = writedata[PRESCALE_W-1:0];
        if (wr_pattern)
            pattern_d = writedata[3:0];

        done_d = (done & ~(wr_status & writedata[1])) | done_set;
        out_d  = (state == RUN) ? s_d : pattern;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            en       <= 1'b0;
            mode     <= 2'd0;
            oneshot  <= 1'b0;
            steps    <= 8'd0;
            period   <= '0;
            pattern  <= 4'h0;
            blink    <= 4'h0;
            s        <= 4'h0;
            cnt      <= '0;
            step_cnt <= 8'd0;
            dir      <= 1'b0;
            done     <= 1'b0;
            out_port <= 4'h0;
        end else begin
            state    <= state_d;
            en       <= en_d;
            mode     <= mode_d;
            oneshot  <= oneshot_d;
            steps    <= steps_d;
            period   <= period_d;
            pattern  <= pattern_d;
            blink    <= blink_d;
            s        <= s_d;
            cnt      <= cnt_d;
            step_cnt <= step_d;
            dir      <= dir_d;
            done     <= done_d;
            out_port <= out_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata = {16'd0, steps, 4'd0, oneshot, mode, en};
            2'd1: readdata = 32'(period);
            2'd2: readdata = {28'd0, pattern};
            2'd3: readdata = {16'd0, step_cnt, 6'd0, done, state == RUN};
        endcase
    end
endmodule

// File: tb/tb_standalone_hps_leds_seq.sv
// Randomized bench for standalone_hps_leds_seq with a
// closed-form model of the LED sequence per mode.
`timescale 1ns/1ps
module tb_standalone_hps_leds_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int checks = 0;
    int errors = 0;

    int         m_n, m_mode, m_period, m_steps;
    bit         m_oneshot;
    logic [3:0] m_start, m_pat;

    always #10 clk = ~clk;

    standalone_hps_leds_seq #(.PRESCALE_W(24)) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata),
        .out_port(out_port)
    );

    // LED value after k ticks, from the mode's visible behaviour.
    function automatic logic [3:0] pat_after(int k);
        logic [7:0] d;
        int b, t, pos;
        case (m_mode)
            0: return m_start;
            1: return (k % 2 == 1) ? 4'h0 : m_start;
            2: begin
                d = {m_start, m_start} << (k % 4);
                return d[7:4];
            end
            default: begin
                b = 0;
                for (int i = 0; i < 4; i++)
                    if (m_start[i]) b = i;
                t = (b + k) % 6;
                pos = (t <= 3) ? t : 6 - t;
                return 4'(1 << pos);
            end
        endcase
    endfunction

    function automatic logic [3:0] exp_out();
        int per, k, last;
        per = m_period + 1;
        k = m_n / per;
        if (m_oneshot) begin
            last = (m_steps == 0) ? 256 : m_steps;
            if (m_n > last * per) return m_pat;
            if (k > last) k = last;
        end
        return pat_after(k);
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d;
        chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic launch(input int mode, input logic [3:0] pat,
                          input int period, input bit os, input int steps);
        wr(2'd2, {28'd0, pat});
        wr(2'd1, 32'(period));
        wr(2'd0, 32'((steps << 8) | (int'(os) << 3) | (mode << 1) | 1));
        m_n = 0; m_mode = mode; m_period = period;
        m_oneshot = os; m_steps = steps;
        m_start = pat; m_pat = pat;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) @(negedge clk);
        checks++;
        if (out_port !== 4'h0) begin
            errors++; $display("FAIL reset_out: got %h want 0", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL reset_rd%0d: got %h want 0", a, v);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_pattern_idle();
        logic [31:0] v;
        logic [3:0] p;
        wr(2'd2, 32'h5);
        @(negedge clk);
        checks++;
        if (out_port !== 4'h5) begin
            errors++; $display("FAIL idle_out: got %h want 5", out_port);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'h5) begin
            errors++; $display("FAIL idle_rd_pat: got %h want 5", v);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL idle_status: got %h want 0", v);
        end
        for (int i = 0; i < 4; i++) begin
            p = 4'($urandom);
            wr(2'd2, {28'd0, p});
            @(negedge clk);
            checks++;
            if (out_port !== p) begin
                errors++; $display("FAIL idle_rand: got %h want %h", out_port, p);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8];
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        launch(3, 4'h1, 3, 1'b0, 0);
        for (int n = 0; n < 32; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (out_port !== seq[n / 4]) begin
                errors++;
                $display("FAIL bounce n=%0d: got %h want %h", n, out_port, seq[n / 4]);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        logic [3:0] seq [5];
        seq = '{4'h9, 4'h3, 4'h6, 4'hC, 4'h9};
        launch(2, 4'h9, 0, 1'b1, 3);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (out_port !== seq[n]) begin
                errors++;
                $display("FAIL oneshot n=%0d: got %h want %h", n, out_port, seq[n]);
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h302) begin
            errors++; $display("FAIL oneshot_status: got %h want 302", v);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h30C) begin
            errors++; $display("FAIL oneshot_ctrl: got %h want 30c", v);
        end
        wr(2'd3, 32'h2);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h300) begin
            errors++; $display("FAIL w1c: got %h want 300", v);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        launch(2, 4'h1, 0, 1'b1, 2);
        wr(2'd3, 32'h2);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h202) begin
            errors++; $display("FAIL set_wins: got %h want 202", v);
        end
        wr(2'd3, 32'hFFFF_FFFD);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h202) begin
            errors++; $display("FAIL status_ro: got %h want 202", v);
        end
    endtask

    task automatic test_blink();
        logic [31:0] v;
        launch(1, 4'hF, 1, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(negedge clk); m_n++; end
            checks++;
            if (out_port !== exp_out()) begin
                errors++;
                $display("FAIL blink n=%0d: got %h want %h", m_n, out_port, exp_out());
            end
        end
        wr(2'd2, 32'h3);
        m_n += 2; m_pat = 4'h3;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(negedge clk); m_n++; end
            checks++;
            if (out_port !== exp_out()) begin
                errors++;
                $display("FAIL blink_midpat n=%0d: got %h want %h", m_n, out_port, exp_out());
            end
        end
        wr(2'd0, 32'h3);
        m_n = 0; m_start = 4'h3;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(negedge clk); m_n++; end
            checks++;
            if (out_port !== exp_out()) begin
                errors++;
                $display("FAIL blink_restart n=%0d: got %h want %h", m_n, out_port, exp_out());
            end
        end
        wr(2'd0, 32'h0);
        @(negedge clk);
        rd(2'd3, v);
        checks++;
        if (out_port !== 4'h3 || v[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL stop: out %h status %h want out 3 status[1:0]=2", out_port, v);
        end
    endtask

    task automatic test_steps_zero();
        logic [31:0] v;
        wr(2'd3, 32'h2);
        launch(2, 4'h1, 0, 1'b1, 0);
        for (int i = 0; i < 255; i++) begin
            @(negedge clk); m_n++;
            checks++;
            if (out_port !== exp_out()) begin
                errors++;
                $display("FAIL steps0 n=%0d: got %h want %h", m_n, out_port, exp_out());
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'hFF01) begin
            errors++; $display("FAIL steps0_busy: got %h want ff01", v);
        end
        @(negedge clk);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL steps0_done: got %h want 2", v);
        end
    endtask

    task automatic test_period_change();
        logic [3:0] e;
        launch(2, 4'h1, 100, 1'b0, 0);
        repeat (49) @(negedge clk);
        wr(2'd1, 32'd2);
        for (int n = 51; n <= 62; n++) begin
            if (n > 51) @(negedge clk);
            m_period = 2; m_start = 4'h1;
            e = (n < 52) ? 4'h1 : pat_after(1 + (n - 52) / 3);
            checks++;
            if (out_port !== e) begin
                errors++;
                $display("FAIL period_chg n=%0d: got %h want %h", n, out_port, e);
            end
        end
    endtask

    task automatic test_random_modes();
        int mode, per, steps;
        bit os;
        logic [3:0] pat;
        for (int it = 0; it < 8; it++) begin
            wr(2'd0, 32'h0);
            mode = $urandom_range(0, 3);
            per = $urandom_range(0, 3);
            os = 1'($urandom);
            steps = $urandom_range(1, 4);
            pat = (mode == 3) ? 4'(1 << $urandom_range(0, 2)) : 4'($urandom);
            launch(mode, pat, per, os, steps);
            for (int i = 0; i < 25; i++) begin
                if (i > 0) begin @(negedge clk); m_n++; end
                checks++;
                if (out_port !== exp_out()) begin
                    errors++;
                    $display("FAIL rand m%0d p%0d n=%0d: got %h want %h",
                             mode, per, m_n, out_port, exp_out());
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        launch(2, 4'h3, 1, 1'b0, 0);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 4'h0) begin
            errors++; $display("FAIL rst_mid_out: got %h want 0", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL rst_mid_rd%0d: got %h want 0", a, v);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd(2'd3, v);
            checks++;
            if (out_port !== 4'h0 || v !== 32'd0) begin
                errors++;
                $display("FAIL rst_after: out %h status %h want 0", out_port, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern_idle();
        test_bounce();
        test_oneshot();
        test_w1c_race();
        test_blink();
        test_steps_zero();
        test_period_change();
        test_random_modes();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/standalone_hps_leds_seq.md
STANDALONE_HPS_LEDS_SEQ -- requirements
Module: standalone_hps_leds_seq

Interface
REQ-001 Parameter PRESCALE_W, default 24, width of the PERIOD register and the tick prescaler.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe; write = chipselect && ~write_n.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  read data, combinational from address, unused bits 0.
REQ-009 out_port  output  4  registered LED drive.

Function
REQ-010 Register map SHALL be:
- 0 CTRL: [0] EN, [2:1] MODE, [3] ONESHOT, [15:8] STEPS.
- 1 PERIOD: [PRESCALE_W-1:0].
- 2 PATTERN: [3:0].
- 3 STATUS: [0] BUSY (read-only), [1] DONE (sticky, write-1-to-clear), [15:8] STEP_CNT (read-only).
REQ-011 Reads SHALL have zero wait states; readdata SHALL return the addressed field zero-extended, with undefined bits 0.
REQ-012 The FSM SHALL have two states: IDLE and RUN; BUSY = (state == RUN).
REQ-013 In IDLE, out_port SHALL equal PATTERN, one cycle after any PATTERN write.
REQ-014 A CTRL write with EN=1 SHALL, on the next edge, enter RUN and load shift reg S=PATTERN, prescaler CNT=0, STEP_CNT=0, DIR=0.
- A CTRL write with EN=1 while already in RUN SHALL restart with the same loads.
REQ-015 A CTRL write with EN=0 SHALL return to IDLE on the next edge; DONE SHALL be unchanged.
REQ-016 In RUN, CNT SHALL increment each cycle; TICK = (CNT >= PERIOD), and on TICK, CNT SHALL become 0.
- PERIOD=0 SHALL tick every cycle.
- Lowering PERIOD below CNT SHALL tick on the next cycle.
REQ-017 On TICK, S SHALL update by MODE:
- 0 static: S unchanged.
- 1 blink: S ^= PATTERN.
- 2 rotate: S = {S[2:0],S[3]}.
- 3 bounce: DIR=0 rotates left; DIR=1 rotates right; DIR sets when the result has bit3=1 and clears when the result has bit0=1.
REQ-018 In RUN, out_port SHALL equal S, registered.
REQ-019 On TICK, STEP_CNT SHALL increment modulo 256.
REQ-020 If ONESHOT=1 and the incremented STEP_CNT equals STEPS, then on that TICK:
- the FSM SHALL enter IDLE, clear EN, and set DONE;
- STEP_CNT SHALL hold its value.
- STEPS=0 with ONESHOT SHALL run 256 ticks.
REQ-021 PATTERN writes during RUN SHALL update the register only; S is unaffected until the next start.
- MODE changes SHALL apply at the next TICK.
REQ-022 If DONE is set and a W1C to DONE occurs in the same cycle, set SHALL win.
REQ-023 Writes to STATUS bits other than DONE, and writes to unused bits, SHALL be ignored.

Reset
REQ-024 While reset_n=0, all registers SHALL be cleared: CTRL, PERIOD, PATTERN, S, CNT, STEP_CNT, DIR, DONE, state=IDLE, out_port=4'h0.
REQ-025 Reset asserted mid-RUN SHALL immediately force the REQ-024 values; after deassertion, the block SHALL stay in IDLE until a new EN write.

Verification
REQ-026 Write PATTERN=0x5 -> out_port=0x5 next cycle; read addr 2 returns 0x00000005; STATUS BUSY=0.
REQ-027 PATTERN=0x1, PERIOD=3, CTRL MODE=3 EN=1 -> out_port every 4 cycles: 1,2,4,8,4,2,1,2.
REQ-028 PATTERN=0x9, PERIOD=0, MODE=2, ONESHOT=1, STEPS=3, EN=1 -> out_port 9,3,6,C, then IDLE showing 0x9; STATUS reads 0x00000302; W1C to DONE reads 0x00000300.
REQ-029 MODE=1, PATTERN=0xF, PERIOD=1, EN=1 -> out_port alternates 0xF/0x0 every 2 cycles; a PATTERN=0x3 write mid-run leaves S unaffected until restart, after which it blinks between 0x3 and 0x0.
REQ-030 Running MODE=2 with PERIOD=100, write PERIOD=2 at CNT=50 -> TICK next cycle, then every 3 cycles.
REQ-031 Assert reset_n mid-RUN -> out_port=0x0 and all readbacks 0 without a clock edge; after release, no activity until EN is written.
